// File: rtl/icache_if.sv
// Fetcher / ROB / memory-controller signal bundle for the instruction cache.
// The slave modport is the cache's view; master is the surrounding pipeline.
interface icache_if;
  logic        IF_pc_sgn;
  logic [31:0] IF_pc;
  logic        IF_ins_sgn;
  logic [31:0] IF_ins;
  logic        ROB_jp_wrong;
  logic        MC_req;
  logic [31:0] MC_addr;
  logic        MC_done;
  logic [31:0] MC_data;

  modport master (
    output IF_pc_sgn, IF_pc, ROB_jp_wrong, MC_done, MC_data,
    input  IF_ins_sgn, IF_ins, MC_req, MC_addr
  );

  modport slave (
    input  IF_pc_sgn, IF_pc, ROB_jp_wrong, MC_done, MC_data,
    output IF_ins_sgn, IF_ins, MC_req, MC_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, 16-byte lines filled one word at a time.
// A mispredict during a fill lets the line install but suppresses its delivery.
module icache #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  icache_if.slave   bus
);
  localparam int unsigned LINES   = 1 << INDEX_BITS;
  localparam int unsigned TAG_W   = 28 - INDEX_BITS;
  localparam int unsigned WADDR_W = INDEX_BITS + 2;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t                  state, state_n;
  logic [31:0]             req_pc, req_pc_n;
  logic [1:0]              k, k_n;
  logic                    drop, drop_n;
  logic                    ins_vld, ins_vld_n;
  logic [31:0]             ins, ins_n;
  logic                    mc_req, mc_req_n;
  logic [31:0]             mc_addr, mc_addr_n;
  logic                    wr_en, install;

  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tags [LINES];
  logic [31:0]             data [LINES*4];

  logic [31:0]             rd_pc;
  logic [INDEX_BITS-1:0]   rd_idx, fill_idx;
  logic [31:0]             rd_word;
  logic                    hit;
  logic                    unused_pc_bits;

  // Lookup uses the live fetch PC in IDLE and the latched PC when responding after a fill
  assign rd_pc    = (state == IDLE) ? bus.IF_pc : req_pc;
  assign rd_idx   = rd_pc[4 +: INDEX_BITS];
  assign rd_word  = data[WADDR_W'({rd_idx, rd_pc[3:2]})];
  assign hit      = valid[rd_idx] && (tags[rd_idx] == rd_pc[31 -: TAG_W]);
  assign fill_idx = req_pc[4 +: INDEX_BITS];
  assign unused_pc_bits = ^rd_pc[1:0];

  // A flush cycle must never show a delivery, even one already registered
  assign bus.IF_ins_sgn = ins_vld & ~bus.ROB_jp_wrong;
  assign bus.IF_ins     = ins;
  assign bus.MC_req     = mc_req;
  assign bus.MC_addr    = mc_addr;

  always_comb begin
    state_n   = state;
    req_pc_n  = req_pc;
    k_n       = k;
    drop_n    = drop;
    ins_vld_n = 1'b0;
    ins_n     = ins;
    mc_req_n  = mc_req;
    mc_addr_n = mc_addr;
    wr_en     = 1'b0;
    install   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.IF_pc_sgn) begin
          req_pc_n = bus.IF_pc;
          if (hit) begin
            ins_vld_n = 1'b1;
            ins_n     = rd_word;
          end else begin
            state_n   = FILL;
            k_n       = 2'd0;
            mc_req_n  = 1'b1;
            mc_addr_n = {bus.IF_pc[31:4], 4'b0000};
          end
        end
      end
      FILL: begin
        if (bus.ROB_jp_wrong) drop_n = 1'b1;
        if (bus.MC_done) begin
          wr_en     = 1'b1;
          k_n       = k + 2'd1;
          mc_addr_n = mc_addr + 32'd4;
          if (k == 2'd3) begin
            mc_req_n = 1'b0;
            install  = 1'b1;
            state_n  = RESP;
          end
        end
      end
      RESP: begin
        if (!drop && !bus.ROB_jp_wrong) begin
          ins_vld_n = 1'b1;
          ins_n     = rd_word;
        end
        drop_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_pc  <= 32'd0;
      k       <= 2'd0;
      drop    <= 1'b0;
      ins_vld <= 1'b0;
      ins     <= 32'd0;
      mc_req  <= 1'b0;
      mc_addr <= 32'd0;
      valid   <= '0;
    end else if (rdy) begin
      state   <= state_n;
      req_pc  <= req_pc_n;
      k       <= k_n;
      drop    <= drop_n;
      ins_vld <= ins_vld_n;
      ins     <= ins_n;
      mc_req  <= mc_req_n;
      mc_addr <= mc_addr_n;
      if (install) valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset; the valid bits guard them
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (wr_en)   data[WADDR_W'({fill_idx, k})] <= bus.MC_data;
      if (install) tags[fill_idx] <= req_pc[31 -: TAG_W];
    end
  end
endmodule
